// File: rtl/dsi_lanes_rx_merger.sv
// rtl/dsi_lanes_rx_merger.sv - DSI receive lane merger: re-interleaves lane bytes into 32-bit words
//
// Purpose: merges per-lane HS byte streams (already SoT-aligned and deskewed)
// back into the transmit byte order (byte n on lane n mod N), packs them into
// little-endian 32-bit words with strobes and a last flag, and queues them in
// a show-ahead FIFO for the packet parser.
//
// Optional feature: define DSI_RX_STATS_EN to add per-burst statistics outputs.
//
// Ports:
//   clk_sys, rst            clock, asynchronous active-high reset
//   reg_lanes_number[1:0]   active lanes minus 1, latched on burst start
//   lane_active[3:0]        per-lane burst envelope
//   lane_valid[3:0]         per-lane byte strobe
//   lane_data[31:0]         lane i byte on [8i+7:8i]
//   out_data/strb/last      FIFO head word, strobes, final-word flag
//   out_valid, out_ready    output handshake
//   rx_busy                 FSM not idle
//   err_skew/overflow/timeout  sticky error flags, cleared by err_clear
//   stat_burst_bytes/count  (DSI_RX_STATS_EN) last-burst byte count, burst count
module dsi_lanes_rx_merger #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [1:0]  reg_lanes_number,
  input  logic [3:0]  lane_active,
  input  logic [3:0]  lane_valid,
  input  logic [31:0] lane_data,
  output logic [31:0] out_data,
  output logic [3:0]  out_strb,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        rx_busy,
  output logic        err_skew,
  output logic        err_overflow,
  output logic        err_timeout,
  input  logic        err_clear
`ifdef DSI_RX_STATS_EN
  ,
  output logic [15:0] stat_burst_bytes,
  output logic [15:0] stat_burst_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
  state_t state, state_nx;

  logic [1:0]    lanes_n;
  logic [TW-1:0] idle_cnt;
  logic          short_seen;
  logic [23:0]   acc_data, acc_data_nx;
  logic [2:0]    acc_cnt, acc_cnt_nx;
  logic [31:0]   stg_data, stg_data_nx;
  logic          stg_v, stg_v_nx;

  logic [3:0]  en_mask, v;
  logic        legal, intake, skew_evt, timeout_evt, start;
  logic [2:0]  k;
  logic [31:0] byte_mask;
  logic [55:0] comb;
  logic [3:0]  total;
  logic [3:0]  acc_strb;

  // FIFO entries are {last, strb, data}
  logic [36:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [36:0]   push_a, push_b;
  logic [1:0]    push_n, acc_n;
  logic [CW:0]   free_sp;
  logic          pop, ovf_evt;

  always_comb begin
    en_mask = 4'b0001;
    case (lanes_n)
      2'd1:    en_mask = 4'b0011;
      2'd2:    en_mask = 4'b0111;
      2'd3:    en_mask = 4'b1111;
      default: en_mask = 4'b0001;
    endcase
    v = lane_valid & en_mask;
    legal = 1'b0;
    k = 3'd0;
    byte_mask = 32'h0;
    case (v)
      4'b0001: begin legal = 1'b1; k = 3'd1; byte_mask = 32'h0000_00FF; end
      4'b0011: begin legal = 1'b1; k = 3'd2; byte_mask = 32'h0000_FFFF; end
      4'b0111: begin legal = 1'b1; k = 3'd3; byte_mask = 32'h00FF_FFFF; end
      4'b1111: begin legal = 1'b1; k = 3'd4; byte_mask = 32'hFFFF_FFFF; end
      default: ;
    endcase
    // Once a short cycle (k < N) has been seen, the burst must be over.
    intake   = (state == ACTIVE) && legal && !short_seen;
    skew_evt = (state == ACTIVE) && (v != 4'b0000) && (!legal || short_seen);
  end

  always_comb begin
    state_nx    = state;
    timeout_evt = 1'b0;
    start       = 1'b0;
    case (state)
      IDLE: if (lane_active[0]) begin
        state_nx = ACTIVE;
        start    = 1'b1;
      end
      ACTIVE: begin
        if ((lane_active & en_mask) == 4'b0000) begin
          state_nx = FLUSH;
        end else if (idle_cnt == TMO) begin
          state_nx    = FLUSH;
          timeout_evt = 1'b1;
        end
      end
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Accumulator, staging register and FIFO push requests.
  always_comb begin
    acc_data_nx = acc_data;
    acc_cnt_nx  = acc_cnt;
    stg_data_nx = stg_data;
    stg_v_nx    = stg_v;
    push_n      = 2'd0;
    push_a      = 37'h0;
    push_b      = 37'h0;
    comb  = {32'h0, acc_data} | ({24'h0, lane_data & byte_mask} << {acc_cnt, 3'b000});
    total = {1'b0, acc_cnt} + {1'b0, k};
    case (acc_cnt)
      3'd1:    acc_strb = 4'b0001;
      3'd2:    acc_strb = 4'b0011;
      3'd3:    acc_strb = 4'b0111;
      default: acc_strb = 4'b0000;
    endcase
    if (intake) begin
      // The staged word is known not to be last once another byte arrives.
      if (stg_v) begin
        push_a = {1'b0, 4'hF, stg_data};
        push_n = 2'd1;
      end
      if (total >= 4'd4) begin
        stg_data_nx = comb[31:0];
        stg_v_nx    = 1'b1;
        acc_data_nx = comb[55:32];
        acc_cnt_nx  = 3'(total - 4'd4);
      end else begin
        stg_v_nx    = 1'b0;
        acc_data_nx = comb[23:0];
        acc_cnt_nx  = total[2:0];
      end
    end else if (state == FLUSH) begin
      if (acc_cnt != 3'd0) begin
        if (stg_v) begin
          push_a = {1'b0, 4'hF, stg_data};
          push_b = {1'b1, acc_strb, 8'h00, acc_data};
          push_n = 2'd2;
        end else begin
          push_a = {1'b1, acc_strb, 8'h00, acc_data};
          push_n = 2'd1;
        end
      end else if (stg_v) begin
        push_a = {1'b1, 4'hF, stg_data};
        push_n = 2'd1;
      end
      acc_data_nx = 24'h0;
      acc_cnt_nx  = 3'd0;
      stg_v_nx    = 1'b0;
    end
  end

  // A pop in the same cycle frees a slot, so push-at-full with pop never drops.
  always_comb begin
    pop     = out_valid && out_ready;
    free_sp = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_cnt} + {{CW{1'b0}}, pop};
    if ({{(CW-1){1'b0}}, push_n} <= free_sp) acc_n = push_n;
    else                                      acc_n = free_sp[1:0];
    ovf_evt = (acc_n != push_n);
  end

  always_ff @(posedge clk_sys) begin
    if (acc_n != 2'd0) mem[wr_ptr] <= push_a;
    if (acc_n == 2'd2) mem[wr_ptr + AW'(1)] <= push_b;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lanes_n      <= 2'd0;
      idle_cnt     <= '0;
      short_seen   <= 1'b0;
      acc_data     <= 24'h0;
      acc_cnt      <= 3'd0;
      stg_data     <= 32'h0;
      stg_v        <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      err_skew     <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      acc_data <= acc_data_nx;
      acc_cnt  <= acc_cnt_nx;
      stg_data <= stg_data_nx;
      stg_v    <= stg_v_nx;
      if (start) begin
        lanes_n    <= reg_lanes_number;
        idle_cnt   <= '0;
        short_seen <= 1'b0;
      end else if (state == ACTIVE) begin
        if (intake) idle_cnt <= '0;
        else if (idle_cnt != TMO) idle_cnt <= idle_cnt + TW'(1);
        if (intake && (k < ({1'b0, lanes_n} + 3'd1))) short_seen <= 1'b1;
      end
      wr_ptr   <= wr_ptr + AW'(acc_n);
      rd_ptr   <= rd_ptr + AW'(pop);
      fifo_cnt <= fifo_cnt + CW'(acc_n) - CW'(pop);
      if (err_clear) begin
        err_skew     <= 1'b0;
        err_overflow <= 1'b0;
        err_timeout  <= 1'b0;
      end else begin
        err_skew     <= err_skew | skew_evt;
        err_overflow <= err_overflow | ovf_evt;
        err_timeout  <= err_timeout | timeout_evt;
      end
    end
  end

`ifdef DSI_RX_STATS_EN
  logic [15:0] burst_bytes;
  logic [16:0] bytes_sum;
  assign bytes_sum = {1'b0, burst_bytes} + {14'h0, k};

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      burst_bytes      <= 16'h0;
      stat_burst_bytes <= 16'h0;
      stat_burst_count <= 16'h0;
    end else begin
      if (start) burst_bytes <= 16'h0;
      else if (intake) burst_bytes <= bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
      if (state == FLUSH) begin
        stat_burst_bytes <= burst_bytes;
        stat_burst_count <= stat_burst_count + 16'd1;
      end
    end
  end
`endif

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = out_valid ? mem[rd_ptr][31:0]  : 32'h0;
  assign out_strb  = out_valid ? mem[rd_ptr][35:32] : 4'h0;
  assign out_last  = out_valid ? mem[rd_ptr][36]    : 1'b0;
  assign rx_busy   = (state != IDLE);

endmodule
